// File: rtl/skewed_weight_bank_pkg.sv
// Shared configuration for the skewed weight bank: default geometry, read-mode
// encoding and pointer sizing.
package skewed_weight_bank_pkg;

    localparam int unsigned sys_cols       = 4;
    localparam int unsigned W_BITWIDTH     = 8;
    localparam int unsigned w_buffer_depth = 4;

    typedef enum logic {
        ALIGNED = 1'b0,
        SKEW    = 1'b1
    } mode_e;

    // Pointer width: address bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_column_fifo.sv
// One weight column: circular store with write, read and mark pointers, where
// the mark lets retained entries be replayed after a rewind.
module wb_column_fifo
    import skewed_weight_bank_pkg::*;
#(
    parameter int unsigned DWIDTH = W_BITWIDTH,
    parameter int unsigned DEPTH  = w_buffer_depth
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         wr_en,
    input  logic [DWIDTH-1:0]            i_data,
    input  logic                         rd_req,
    input  logic                         retain,
    input  logic                         rewind,
    output logic                         o_valid,
    output logic [DWIDTH-1:0]            o_data,
    output logic                         full_c,
    output logic                         empty_c,
    output logic [$clog2(DEPTH+1)-1:0]   count_c,
    output logic                         ovf_c,
    output logic                         udf_c
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned AW = PW - 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     mark_ptr;
    logic [PW-1:0]     used;
    logic [PW-1:0]     held;
    logic              do_wr;
    logic              do_rd;

    // Space is bounded by the mark, not the read pointer, so retained words are never overwritten.
    assign held    = wr_ptr - mark_ptr;
    assign used    = wr_ptr - rd_ptr;
    assign full_c  = (held == PW'(DEPTH));
    assign empty_c = (wr_ptr == rd_ptr);
    assign count_c = CW'(used);

    assign do_wr = wr_en & ~full_c;
    assign do_rd = rd_req & ~empty_c & ~rewind;
    assign ovf_c = wr_en & full_c;
    assign udf_c = rd_req & empty_c;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mark_ptr <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
        end else begin
            o_valid <= do_rd;
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rewind) begin
                rd_ptr <= mark_ptr;
            end else if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
                o_data <= mem[rd_ptr[AW-1:0]];
                if (!retain) begin
                    mark_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/skewed_weight_bank.sv
// Bank of independent weight columns whose reads are either issued together or
// staggered one cycle per column along a diagonal skew chain.
module skewed_weight_bank
    import skewed_weight_bank_pkg::*;
#(
    parameter int unsigned NUM_COLS = sys_cols,
    parameter int unsigned DWIDTH   = W_BITWIDTH,
    parameter int unsigned DEPTH    = w_buffer_depth
) (
    input  logic                                       clk,
    input  logic                                       rstn,
    input  logic [NUM_COLS-1:0]                        wr_en,
    input  logic [NUM_COLS-1:0][DWIDTH-1:0]            i_data,
    input  logic                                       read,
    input  logic                                       skew_mode,
    input  logic                                       retain,
    input  logic                                       rewind,
    output logic [NUM_COLS-1:0]                        o_valid,
    output logic [NUM_COLS-1:0][DWIDTH-1:0]            o_data,
    output logic [NUM_COLS-1:0]                        full,
    output logic [NUM_COLS-1:0]                        empty,
    output logic [NUM_COLS-1:0][$clog2(DEPTH+1)-1:0]   count,
    output logic                                       overflow,
    output logic                                       underflow,
    output logic                                       busy
);

    logic [NUM_COLS-1:0] sk_q;
    logic [NUM_COLS-1:0] sk_d;
    logic [NUM_COLS-1:0] rd_req;
    logic [NUM_COLS-1:0] ovf_c;
    logic [NUM_COLS-1:0] udf_c;
    mode_e               mode_q;
    mode_e               mode_c;
    logic                rewind_ok;

    // Mode may only change while the chain is drained; otherwise the latched mode holds.
    assign busy      = |sk_q;
    assign mode_c    = busy ? mode_q : mode_e'(skew_mode);
    assign rewind_ok = rewind & ~read & ~busy;

    always_comb begin
        rd_req    = '0;
        sk_d      = '0;
        rd_req[0] = read;
        for (int c = 1; c < NUM_COLS; c++) begin
            rd_req[c] = (mode_c == SKEW) ? sk_q[c] : read;
            sk_d[c]   = (mode_c == SKEW) & rd_req[c-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sk_q      <= '0;
            mode_q    <= SKEW;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sk_q      <= sk_d;
            mode_q    <= mode_c;
            overflow  <= overflow | (|ovf_c);
            underflow <= underflow | (|udf_c);
        end
    end

    for (genvar gc = 0; gc < NUM_COLS; gc++) begin : g_col
        wb_column_fifo #(
            .DWIDTH (DWIDTH),
            .DEPTH  (DEPTH)
        ) u_col (
            .clk     (clk),
            .rstn    (rstn),
            .wr_en   (wr_en[gc]),
            .i_data  (i_data[gc]),
            .rd_req  (rd_req[gc]),
            .retain  (retain),
            .rewind  (rewind_ok),
            .o_valid (o_valid[gc]),
            .o_data  (o_data[gc]),
            .full_c  (full[gc]),
            .empty_c (empty[gc]),
            .count_c (count[gc]),
            .ovf_c   (ovf_c[gc]),
            .udf_c   (udf_c[gc])
        );
    end

endmodule

// File: tb/tb_skewed_weight_bank.sv
// Self-checking bench for skewed_weight_bank: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_skewed_weight_bank;

    localparam int unsigned NC = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned DP = 4;
    localparam int unsigned CW = $clog2(DP + 1);

    logic                       clk = 1'b0;
    logic                       rstn = 1'b0;
    logic [NC-1:0]              wr_en = '0;
    logic [NC-1:0][DW-1:0]      i_data = '0;
    logic                       read = 1'b0;
    logic                       skew_mode = 1'b1;
    logic                       retain = 1'b0;
    logic                       rewind = 1'b0;
    logic [NC-1:0]              o_valid;
    logic [NC-1:0][DW-1:0]      o_data;
    logic [NC-1:0]              full;
    logic [NC-1:0]              empty;
    logic [NC-1:0][CW-1:0]      count;
    logic                       overflow;
    logic                       underflow;
    logic                       busy;

    skewed_weight_bank #(
        .NUM_COLS (NC),
        .DWIDTH   (DW),
        .DEPTH    (DP)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en     (wr_en),
        .i_data    (i_data),
        .read      (read),
        .skew_mode (skew_mode),
        .retain    (retain),
        .rewind    (rewind),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted word is kept forever; columns index it with unbounded counters.
    logic [DW-1:0]         wq [NC][$];
    int                    rd_i [NC];
    int                    mk_i [NC];
    logic [NC-1:0]         e_valid;
    logic [NC-1:0][DW-1:0] e_data;
    logic                  e_ovf;
    logic                  e_udf;
    logic                  m_mode;
    logic [NC-1:0]         hist;   // hist[k]: a skewed read issued k cycles ago still owed to column k

    task automatic m_reset();
        for (int c = 0; c < NC; c++) begin
            wq[c].delete();
            rd_i[c] = 0;
            mk_i[c] = 0;
        end
        e_valid = '0;
        e_data  = '0;
        e_ovf   = 1'b0;
        e_udf   = 1'b0;
        m_mode  = 1'b1;
        hist    = '0;
    endtask

    task automatic m_step();
        bit            busy_m;
        bit            skew;
        bit            rw_ok;
        bit            is_full;
        bit            is_empty;
        logic [NC-1:0] req;
        int            wr_n;
        busy_m = |hist[NC-1:1];
        skew   = busy_m ? m_mode : skew_mode;
        rw_ok  = rewind && !read && !busy_m;
        for (int c = 0; c < NC; c++) begin
            req[c] = (c == 0) ? read : (skew ? hist[c] : read);
        end
        for (int c = 0; c < NC; c++) begin
            wr_n     = wq[c].size();
            is_full  = (wr_n - mk_i[c]) == DP;
            is_empty = (wr_n == rd_i[c]);
            e_valid[c] = 1'b0;
            if (wr_en[c]) begin
                if (is_full) e_ovf = 1'b1;
                else wq[c].push_back(i_data[c]);
            end
            if (rw_ok) begin
                rd_i[c] = mk_i[c];
            end else if (req[c]) begin
                if (is_empty) begin
                    e_udf = 1'b1;
                end else begin
                    e_data[c]  = wq[c][rd_i[c]];
                    e_valid[c] = 1'b1;
                    rd_i[c]++;
                    if (!retain) mk_i[c] = rd_i[c];
                end
            end
        end
        hist    = hist << 1;
        hist[1] = read && skew;
        m_mode  = skew;
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) m_reset();
        else m_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [NC-1:0]         x_full;
            logic [NC-1:0]         x_empty;
            logic [NC-1:0][CW-1:0] x_count;
            for (int c = 0; c < NC; c++) begin
                x_full[c]  = (wq[c].size() - mk_i[c]) == DP;
                x_empty[c] = (wq[c].size() == rd_i[c]);
                x_count[c] = CW'(wq[c].size() - rd_i[c]);
            end
            chk("o_valid", 64'(o_valid), 64'(e_valid));
            chk("o_data", 64'(o_data), 64'(e_data));
            chk("full", 64'(full), 64'(x_full));
            chk("empty", 64'(empty), 64'(x_empty));
            chk("count", 64'(count), 64'(x_count));
            chk("overflow", 64'(overflow), 64'(e_ovf));
            chk("underflow", 64'(underflow), 64'(e_udf));
            chk("busy", 64'(busy), 64'(|hist[NC-1:1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [NC-1:0] m, input int tag);
        for (int k = 0; k < n; k++) begin
            wr_en = m;
            for (int c = 0; c < NC; c++) i_data[c] = DW'(tag + c * 16 + k);
            tick();
        end
        wr_en = '0;
    endtask

    logic [NC-1:0] exp_a [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

    initial begin
        @(negedge clk);
        #1;
        chk("rst_empty", 64'(empty), 64'hF);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_count", 64'(count), 64'h0);
        #2 rstn = 1'b1;
        chk_en = 1'b1;

        // Diagonal skew: column c valid for cycles c+1..c+3
        skew_mode = 1'b1;
        fill(3, '1, 0);
        for (int i = 0; i < 7; i++) begin
            read = (i < 3);
            tick();
            chk("skew_valid", 64'(o_valid), 64'(exp_a[i]));
            if (i == 0) chk("skew_c0_w0", 64'(o_data[0]), 64'h00);
            if (i == 2) chk("skew_c0_w2", 64'(o_data[0]), 64'h02);
            if (i == 3) chk("skew_c3_w0", 64'(o_data[3]), 64'h30);
        end
        read = 1'b0;

        // Aligned: all columns together, no busy
        skew_mode = 1'b0;
        tick();
        fill(3, '1, 0);
        for (int i = 0; i < 3; i++) begin
            read = 1'b1;
            tick();
            chk("aligned_valid", 64'(o_valid), 64'hF);
            chk("aligned_busy", 64'(busy), 64'h0);
        end
        read = 1'b0;
        tick();

        // Overflow: five writes into a four-deep column
        fill(5, 4'b0001, 8'hA0);
        chk("ovf_full0", 64'(full[0]), 64'h1);
        chk("ovf_count0", 64'(count[0]), 64'h4);
        chk("ovf_flag", 64'(overflow), 64'h1);

        // Retained replay after rewind
        retain = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4; i++) begin
                read = 1'b1;
                tick();
                chk("replay_data", 64'(o_data[0]), 64'(8'hA0 + i));
                chk("replay_full", 64'(full[0]), 64'h1);
            end
            read   = 1'b0;
            rewind = (pass == 0);
            tick();
            rewind = 1'b0;
            chk("replay_full_rw", 64'(full[0]), 64'h1);
        end
        retain = 1'b0;

        // Underflow on empty column
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        read = 1'b1;
        tick();
        read = 1'b0;
        chk("udf_valid2", 64'(o_valid[2]), 64'h0);
        chk("udf_flag", 64'(underflow), 64'h1);
        chk("udf_count2", 64'(count[2]), 64'h0);

        // Rewind while busy is ignored
        skew_mode = 1'b1;
        fill(2, '1, 0);
        retain = 1'b1;
        read   = 1'b1;
        tick();
        read   = 1'b0;
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        repeat (4) tick();
        chk("busy_rw_count0", 64'(count[0]), 64'h1);
        chk("busy_rw_count3", 64'(count[3]), 64'h1);
        retain = 1'b0;

        // Reset in the middle of a skewed read
        read = 1'b1;
        tick();
        tick();
        #1 rstn = 1'b0;
        #1;
        chk("midrst_valid", 64'(o_valid), 64'h0);
        chk("midrst_data", 64'(o_data), 64'h0);
        chk("midrst_empty", 64'(empty), 64'hF);
        chk("midrst_busy", 64'(busy), 64'h0);
        read = 1'b0;
        tick();
        #1 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", 64'(o_valid), 64'h0);
        end

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            wr_en = NC'($urandom);
            for (int c = 0; c < NC; c++) i_data[c] = DW'($urandom);
            read   = ($urandom_range(2) == 0);
            retain = ($urandom_range(3) == 0);
            rewind = ($urandom_range(9) == 0);
            if ($urandom_range(7) == 0) skew_mode = ~skew_mode;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
